imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Loads a program into instruction memory from a byte stream and holds the
// CPU in reset until the load finishes.
//
// Stream: LEN_LO, LEN_HI (16-bit little-endian word count N), then N words
// of four bytes each, least-significant byte first.
//
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN): a running XOR of every
// data byte is kept. One extra checksum byte follows the last word. A match
// ends in DONE and a mismatch ends in ERR. With the macro undefined there is
// no checksum state or logic, and the load ends directly in DONE.
//
// Parameters:
//   ADDR_W     instruction-memory word-address width (capacity 2**ADDR_W)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      pulse; starts a load from IDLE, DONE or ERR
//   rx_valid   byte-stream valid
//   rx_data    byte-stream data
//   rx_ready   loader accepts a byte (transfer = rx_valid & rx_ready)
//   imem_we    one-cycle write strobe per assembled word
//   imem_addr  word address of the write
//   imem_wdata assembled instruction word
//   cpu_rst    high except after a successful load
//   done       level, load completed successfully
//   err        level, load aborted
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;
  localparam state_t S_AFTER_DATA = S_CSUM;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR
  } state_t;
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  localparam logic [31:0] CAPACITY = 32'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                rx_ready_q, rx_ready_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic                xfer;
  logic                loading;
  logic [15:0]         len_new;
  logic                last_word;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    xfer       = rx_valid && rx_ready_q;
    len_new    = {rx_data, len_q[7:0]};
    // The address is widened before the compare, so a full-capacity load
    // (N = 2**ADDR_W) still finds its last word.
    last_word  = (32'(addr_q) + 32'd1) == 32'(len_q);

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN0;
          addr_d     = '0;
          byte_idx_d = '0;
          wdata_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_LEN0: begin
        if (xfer) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d[15:8] = rx_data;
          if (len_new == 16'd0)
            state_d = S_AFTER_DATA;
          else if (32'(len_new) > CAPACITY)
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        // The cycle after a write strobe advances the address. After the
        // last word the address is left alone, so it never wraps.
        if (we_q) begin
          if (last_word)
            state_d = S_AFTER_DATA;
          else
            addr_d = addr_q + ADDR_W'(1);
        end else if (xfer) begin
          wdata_d    = {rx_data, wdata_q[31:8]};
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ rx_data;
`endif
          if (byte_idx_q == 2'd3)
            we_d = 1'b1;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer)
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // All outputs are registered from the next-state view, so they line up
    // with the state they describe.
    loading = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    loading = loading || (state_d == S_CSUM);
`endif
    rx_ready_d = loading && !we_d;
    cpu_rst_d  = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      byte_idx_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rx_ready_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rx_ready_q <= rx_ready_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
